// File: rtl/wb_byte_master_pkg.sv
// Shared encodings for the Wishbone byte master: transfer sizes, FSM states, lane masks.
// Pure constants and one helper function, no logic.
// Lanes are big-endian: byte offset 0 lives on bits [31:24] / sel[3].
package wb_byte_master_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_B0   = 4'b1000;
  localparam logic [3:0] SEL_H0   = 4'b1100;
  localparam logic [3:0] SEL_H1   = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte lane select for a byte offset (offset 0 -> 1000, offset 3 -> 0001).
  function automatic logic [3:0] byte_sel(input logic [1:0] off);
    return SEL_B0 >> off;
  endfunction

endpackage

// File: rtl/wb_lane_map.sv
// Purpose: maps size/offset to Wishbone byte selects, replicates write data, extracts read data.
// Latency: purely combinational.
// Backpressure: none; misalign also flags the illegal size encoding.
module wb_lane_map
  import wb_byte_master_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  // Decode lane selects and data steering for the current size/offset.
  always_comb begin
    sel       = SEL_NONE;
    wdata_rep = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    case (size)
      SIZE_BYTE: begin
        sel       = byte_sel(off);
        wdata_rep = {4{wdata[7:0]}};
        case (off)
          2'd0:    rdata_ext = {24'd0, rdata[31:24]};
          2'd1:    rdata_ext = {24'd0, rdata[23:16]};
          2'd2:    rdata_ext = {24'd0, rdata[15:8]};
          default: rdata_ext = {24'd0, rdata[7:0]};
        endcase
      end
      SIZE_HALF: begin
        misalign  = off[0];
        sel       = off[0] ? SEL_NONE : (off[1] ? SEL_H1 : SEL_H0);
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = off[1] ? {16'd0, rdata[15:0]} : {16'd0, rdata[31:16]};
      end
      SIZE_WORD: begin
        misalign  = (off != 2'd0);
        sel       = misalign ? SEL_NONE : SEL_WORD;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_byte_master.sv
// Purpose: Wishbone B3 classic single-transfer initiator driven by a valid/ready command stream.
// Latency: accept N, cyc N+1, earliest response N+2; rejected commands respond at N+1.
// Backpressure: one transfer outstanding; cmd_ready low in BUS/RESP, response held until rsp_ready.
module wb_byte_master
  import wb_byte_master_pkg::*;
#(
  parameter int ADR_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 wbm_clk,
  input  logic                 wbm_rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [1:0]           cmd_size,
  input  logic [ADR_WIDTH-1:0] cmd_adr,
  input  logic [31:0]          cmd_dat,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_dat,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic [ADR_WIDTH-1:0] wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  output logic [3:0]           wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  input  logic [31:0]          wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i
);

  // A zero TIMEOUT disables the abort; the counter then collapses to one idle bit.
  localparam int             CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  TO_MAX = CW'(TIMEOUT);
  localparam bit             TO_EN  = (TIMEOUT != 0);

  state_t        state, state_nxt;
  logic [1:0]    cur_size;
  logic [CW-1:0] to_cnt;
  logic [1:0]    map_size, map_off;
  logic [3:0]    lane_sel;
  logic [31:0]   lane_wdat, lane_rdat;
  logic          lane_misalign;
  logic          accept, term_ack, term_err, term_to, term_any;

  assign cmd_ready = (state == ST_IDLE) && !wbm_rst;
  assign accept    = cmd_valid && cmd_ready;
  assign wbm_stb_o = wbm_cyc_o;

  // err dominates ack; timeout only fires when the slave stays silent.
  assign term_err = (state == ST_BUS) && wbm_err_i;
  assign term_ack = (state == ST_BUS) && wbm_ack_i && !wbm_err_i;
  assign term_to  = (state == ST_BUS) && TO_EN && !wbm_ack_i && !wbm_err_i && (to_cnt == TO_MAX);
  assign term_any = term_err || term_ack || term_to;

  // The lane map sees the incoming command in IDLE and the latched transfer afterwards.
  assign map_size = (state == ST_IDLE) ? cmd_size : cur_size;
  assign map_off  = (state == ST_IDLE) ? cmd_adr[1:0] : wbm_adr_o[1:0];

  wb_lane_map u_lane_map (
    .size      (map_size),
    .off       (map_off),
    .wdata     (cmd_dat),
    .rdata     (wbm_dat_i),
    .sel       (lane_sel),
    .wdata_rep (lane_wdat),
    .rdata_ext (lane_rdat),
    .misalign  (lane_misalign)
  );

  // State register.
  always_ff @(posedge wbm_clk) begin
    if (wbm_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = lane_misalign ? ST_RESP : ST_BUS;
      ST_BUS:  if (term_any)  state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs, timeout counter and response registers.
  always_ff @(posedge wbm_clk) begin
    if (wbm_rst) begin
      wbm_cyc_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= SEL_NONE;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      cur_size    <= SIZE_BYTE;
      to_cnt      <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_dat     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (lane_misalign) begin
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_dat     <= '0;
            end else begin
              wbm_cyc_o <= 1'b1;
              wbm_we_o  <= cmd_we;
              wbm_adr_o <= cmd_adr;
              wbm_sel_o <= lane_sel;
              wbm_dat_o <= lane_wdat;
              cur_size  <= cmd_size;
              to_cnt    <= '0;
            end
          end
        end
        ST_BUS: begin
          if (term_any) begin
            wbm_cyc_o   <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= term_err || term_to;
            rsp_timeout <= term_to;
            rsp_dat     <= (term_ack && !wbm_we_o) ? lane_rdat : 32'd0;
          end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed bench for wb_byte_master with a response scoreboard.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_wb_byte_master;

  logic        wbm_clk = 1'b0;
  logic        wbm_rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_adr, cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_dat;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;

  always #5 wbm_clk = ~wbm_clk;

  wb_byte_master #(.ADR_WIDTH(32), .TIMEOUT(8)) dut (
    .wbm_clk(wbm_clk), .wbm_rst(wbm_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_size(cmd_size), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic        tmo;
  } exp_t;
  exp_t sb[$];

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge wbm_clk);
  endtask

  task automatic expect_rsp(input logic [31:0] dat, input logic err, input logic tmo);
    exp_t e;
    e.dat = dat;
    e.err = err;
    e.tmo = tmo;
    sb.push_back(e);
  endtask

  // Present one command for a single cycle; it must be accepted on the next rising edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] adr,
                       input logic [31:0] dat);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_size  = size;
    cmd_adr   = adr;
    cmd_dat   = dat;
    chk_b("cmd_ready_idle", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, compare it to the scoreboard head, then consume it.
  task automatic take_rsp(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk_b({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    chk_w({tag, "_sb_depth"}, sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_w({tag, "_rsp_dat"}, rsp_dat, e.dat);
      chk_b({tag, "_rsp_err"}, rsp_err, e.err);
      chk_b({tag, "_rsp_timeout"}, rsp_timeout, e.tmo);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk_b({tag, "_rsp_cleared"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    wbm_rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_size = 2'b00; cmd_adr = '0; cmd_dat = '0;
    rsp_ready = 1'b0;
    wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    repeat (3) step();

    // Reset state
    chk_b("rst_cyc", wbm_cyc_o, 1'b0);
    chk_b("rst_stb", wbm_stb_o, 1'b0);
    chk_b("rst_we", wbm_we_o, 1'b0);
    chk_w("rst_sel", 32'(wbm_sel_o), 32'h0);
    chk_w("rst_adr", wbm_adr_o, 32'h0);
    chk_w("rst_dat_o", wbm_dat_o, 32'h0);
    chk_b("rst_rsp_valid", rsp_valid, 1'b0);
    chk_b("rst_rsp_err", rsp_err, 1'b0);
    chk_b("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk_w("rst_rsp_dat", rsp_dat, 32'h0);
    chk_b("rst_cmd_ready", cmd_ready, 1'b0);
    wbm_rst = 1'b0;
    step();

    // 1: byte write at offset 3, two wait states
    expect_rsp(32'h0, 1'b0, 1'b0);
    issue(1'b1, 2'b00, 32'h1003, 32'h5A);
    chk_b("t1_cyc", wbm_cyc_o, 1'b1);
    chk_b("t1_stb", wbm_stb_o, 1'b1);
    chk_w("t1_sel", 32'(wbm_sel_o), 32'h1);
    chk_w("t1_dat_o", wbm_dat_o, 32'h5A5A5A5A);
    chk_b("t1_we", wbm_we_o, 1'b1);
    chk_w("t1_adr", wbm_adr_o, 32'h1003);
    chk_b("t1_cmd_ready_bus", cmd_ready, 1'b0);
    step();
    chk_b("t1_cyc_hold", wbm_cyc_o, 1'b1);
    chk_w("t1_sel_hold", 32'(wbm_sel_o), 32'h1);
    step();
    wbm_ack_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    chk_b("t1_cyc_drop", wbm_cyc_o, 1'b0);
    take_rsp("t1");

    // 2: half read at offset 2
    expect_rsp(32'h0000ABCD, 1'b0, 1'b0);
    issue(1'b0, 2'b01, 32'h2002, 32'h0);
    chk_w("t2_sel", 32'(wbm_sel_o), 32'h3);
    chk_b("t2_we", wbm_we_o, 1'b0);
    wbm_dat_i = 32'h1234ABCD;
    wbm_ack_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    take_rsp("t2");

    // 3: byte read at offset 0, ack in the first bus cycle
    expect_rsp(32'h00000012, 1'b0, 1'b0);
    issue(1'b0, 2'b00, 32'h0, 32'h0);
    chk_w("t3_sel", 32'(wbm_sel_o), 32'h8);
    wbm_ack_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    chk_b("t3_rsp_latency", rsp_valid, 1'b1);
    chk_b("t3_cyc_drop", wbm_cyc_o, 1'b0);
    take_rsp("t3");

    // 4: misaligned word, illegal size, misaligned half: no bus cycle, error next cycle
    expect_rsp(32'h0, 1'b1, 1'b0);
    issue(1'b0, 2'b10, 32'h3001, 32'h0);
    chk_b("t4w_cyc", wbm_cyc_o, 1'b0);
    chk_b("t4w_rsp_next", rsp_valid, 1'b1);
    take_rsp("t4w");
    expect_rsp(32'h0, 1'b1, 1'b0);
    issue(1'b0, 2'b11, 32'h0, 32'h0);
    chk_b("t4s_cyc", wbm_cyc_o, 1'b0);
    chk_b("t4s_rsp_next", rsp_valid, 1'b1);
    take_rsp("t4s");
    expect_rsp(32'h0, 1'b1, 1'b0);
    issue(1'b1, 2'b01, 32'h0005, 32'hBEEF);
    chk_b("t4h_cyc", wbm_cyc_o, 1'b0);
    take_rsp("t4h");

    // 5a: silent slave with TIMEOUT=8 -> cyc held exactly 9 cycles
    expect_rsp(32'h0, 1'b1, 1'b1);
    issue(1'b0, 2'b10, 32'h100, 32'h0);
    n = 0;
    while (wbm_cyc_o && n < 50) begin
      n++;
      step();
    end
    chk_w("t5_cyc_cycles", n, 32'd9);
    take_rsp("t5to");

    // 5b: ack and err together -> error wins, no data
    expect_rsp(32'h0, 1'b1, 1'b0);
    issue(1'b0, 2'b10, 32'h200, 32'h0);
    wbm_dat_i = 32'hFFFFFFFF;
    wbm_ack_i = 1'b1;
    wbm_err_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    take_rsp("t5ae");

    // 6a: response backpressure for 5 cycles with a competing command
    expect_rsp(32'hCAFEF00D, 1'b0, 1'b0);
    issue(1'b0, 2'b10, 32'h300, 32'h0);
    wbm_dat_i = 32'hCAFEF00D;
    wbm_ack_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_size = 2'b10; cmd_adr = 32'h400; cmd_dat = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk_b("t6_hold_valid", rsp_valid, 1'b1);
      chk_w("t6_hold_dat", rsp_dat, 32'hCAFEF00D);
      chk_b("t6_cmd_ready", cmd_ready, 1'b0);
      chk_b("t6_no_cyc", wbm_cyc_o, 1'b0);
      step();
    end
    cmd_valid = 1'b0;
    take_rsp("t6bp");
    chk_b("t6_no_accept", wbm_cyc_o, 1'b0);

    // 6b: reset during BUS drops the transfer; a late ack is ignored
    issue(1'b0, 2'b10, 32'h500, 32'h0);
    chk_b("t6r_cyc", wbm_cyc_o, 1'b1);
    wbm_rst = 1'b1;
    step();
    wbm_rst = 1'b0;
    chk_b("t6r_cyc_low", wbm_cyc_o, 1'b0);
    chk_b("t6r_no_rsp", rsp_valid, 1'b0);
    wbm_ack_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    repeat (3) step();
    chk_b("t6r_late_ack_rsp", rsp_valid, 1'b0);
    chk_b("t6r_late_ack_cyc", wbm_cyc_o, 1'b0);
    chk_w("t6r_sb_empty", sb.size(), 32'd0);

    // Recovery: aligned word write after the reset
    expect_rsp(32'h0, 1'b0, 1'b0);
    issue(1'b1, 2'b10, 32'h600, 32'h11223344);
    chk_w("t7_sel", 32'(wbm_sel_o), 32'hF);
    chk_w("t7_dat_o", wbm_dat_o, 32'h11223344);
    wbm_ack_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    take_rsp("t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
